// File: rtl/signal_generator_mc.sv
// Multi-channel tone generator: NUM_CH square/PWM/noise/one-shot channels programmed over a
// strobe/address/data bus, volume-weighted, summed and sigma-delta modulated onto one pin.
module signal_generator_mc #(
  parameter int NUM_CH = 3,
  parameter int DIV_W  = 12,
  parameter int LFSR_W = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       write_strobe,
  input  logic [2:0] address,
  input  logic [4:0] data,
  output logic       signal_out,
  output logic [6:0] debug
);

  typedef enum logic [1:0] {
    MODE_SQUARE  = 2'd0,
    MODE_PWM     = 2'd1,
    MODE_NOISE   = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  localparam int FULL  = 3 * NUM_CH;
  localparam int ACC_W = $clog2(2 * FULL);
  localparam logic [ACC_W-1:0] FULL_L = ACC_W'(FULL);
  localparam int DBG_N = (NUM_CH < 4) ? NUM_CH : 4;

  logic             strobe_p0, strobe_p1, strobe_p2;
  logic             wr_stb;
  logic [2:0]       ch_sel;
  logic [NUM_CH-1:0]   raw_bits;
  logic [2*NUM_CH-1:0] vol_bits;
  logic [ACC_W-1:0] acc, mix_sum, mix_s;
  logic             mix_carry;

  // Stage p0..p1 resynchronise the host strobe; p2 holds the previous sample for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_p0 <= 1'b0;
      strobe_p1 <= 1'b0;
      strobe_p2 <= 1'b0;
    end else if (ena) begin
      strobe_p0 <= write_strobe;
      strobe_p1 <= strobe_p0;
      strobe_p2 <= strobe_p1;
    end
  end

  // One write per strobe rising edge; address/data are taken directly on this cycle.
  assign wr_stb = strobe_p1 & ~strobe_p2;

  // Channel select register, shared by all channel-addressed writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_sel <= '0;
    end else if (ena && wr_stb && (address == 3'd7)) begin
      ch_sel <= data[2:0];
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [4:0]        plo, pmid, duty, phase;
    logic [DIV_W-1:0]  period, cnt;
    logic              en, idle, sq, raw, tick, hit;
    logic              wr_plo, wr_pmid, wr_phi, wr_ctrl, wr_duty;
    mode_e             mode;
    logic [1:0]        vol;
    logic [LFSR_W-1:0] lfsr;

    // A select value outside 0..NUM_CH-1 matches no channel, so such writes fall away.
    assign hit     = wr_stb && (ch_sel == 3'(i));
    assign wr_plo  = hit && (address == 3'd0);
    assign wr_pmid = hit && (address == 3'd1);
    assign wr_phi  = hit && (address == 3'd2);
    assign wr_ctrl = hit && (address == 3'd3);
    assign wr_duty = hit && (address == 3'd4);

    // Greater-or-equal so a shortened period takes effect immediately.
    assign tick = en && !idle && (cnt >= period);

    // Raw output bit selected by mode; a disabled channel is silent.
    always_comb begin
      raw = 1'b0;
      if (en) begin
        case (mode)
          MODE_SQUARE:  raw = sq;
          MODE_PWM:     raw = (phase < duty);
          MODE_NOISE:   raw = lfsr[0];
          MODE_ONESHOT: raw = sq;
        endcase
      end
    end

    // Channel registers, period counter and mode state; bus writes land after the tick update.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        plo    <= '0;
        pmid   <= '0;
        period <= '0;
        duty   <= '0;
        en     <= 1'b0;
        mode   <= MODE_SQUARE;
        vol    <= '0;
        cnt    <= '0;
        phase  <= '0;
        sq     <= 1'b0;
        idle   <= 1'b0;
        lfsr   <= LFSR_W'(1);
      end else if (ena) begin
        if (wr_plo)  plo  <= data;
        if (wr_pmid) pmid <= data;
        if (wr_phi)  period <= {data[DIV_W-11:0], pmid, plo};
        if (wr_duty) duty <= data;

        if (!en) begin
          cnt   <= '0;
          phase <= '0;
          sq    <= 1'b0;
          idle  <= 1'b0;
        end else if (tick) begin
          cnt <= '0;
          case (mode)
            MODE_SQUARE:  sq <= ~sq;
            MODE_PWM:     phase <= phase + 5'd1;
            MODE_NOISE:   lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1] ^ lfsr[LFSR_W-2]};
            MODE_ONESHOT: begin
              sq   <= 1'b0;
              idle <= 1'b1;
            end
          endcase
        end else if (!idle) begin
          cnt <= cnt + 1'b1;
        end

        if (wr_ctrl) begin
          en   <= data[4];
          mode <= mode_e'(data[3:2]);
          vol  <= data[1:0];
          if (data[3:2] != mode) begin
            cnt   <= '0;
            phase <= '0;
            sq    <= 1'b0;
            idle  <= 1'b0;
          end
          if (data[4] && (data[3:2] == 2'd3)) begin
            sq   <= 1'b1;
            cnt  <= '0;
            idle <= 1'b0;
          end
        end
      end
    end

    assign raw_bits[i]       = raw;
    assign vol_bits[2*i +: 2] = vol;
  end

  // Volume-weighted sum of all channels plus the running sigma-delta residue.
  always_comb begin
    mix_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (raw_bits[c]) mix_sum = mix_sum + ACC_W'(vol_bits[2*c +: 2]);
    end
    mix_s     = acc + mix_sum;
    mix_carry = (mix_s >= FULL_L);
  end

  // Output stage: first-order sigma-delta, output is the carry out of the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      signal_out <= 1'b0;
    end else if (ena) begin
      signal_out <= mix_carry;
      acc        <= mix_carry ? (mix_s - FULL_L) : mix_s;
    end
  end

  assign debug = {ch_sel, 4'(raw_bits[DBG_N-1:0])};

endmodule

// File: tb/tb_signal_generator_mc.sv
// Bench for signal_generator_mc: vector table, directed multi-cycle sequences and a random
// bus-write phase, all checked cycle by cycle against a tick-count based reference model.
module tb_signal_generator_mc;

  localparam int NCH  = 3;
  localparam int FULL = 3 * NCH;

  logic       clk = 1'b0;
  logic       rst_n, ena, write_strobe;
  logic [2:0] address;
  logic [4:0] data;
  logic       signal_out;
  logic [6:0] debug;

  signal_generator_mc #(.NUM_CH(NCH), .DIV_W(12), .LFSR_W(15)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .write_strobe(write_strobe),
    .address(address), .data(data), .signal_out(signal_out), .debug(debug)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: each channel is described by its tick count since (re)start.
  int          m_period[NCH], m_plo[NCH], m_pmid[NCH], m_duty[NCH];
  int          m_cnt[NCH], m_nt[NCH], m_mode[NCH], m_vol[NCH];
  bit          m_en[NCH];
  int unsigned m_lfsr[NCH];
  int          m_sel;
  longint      m_total;
  bit          m_sout;
  bit          pend;
  int          pend_n, pend_a, pend_d;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_raw(int c);
    if (!m_en[c]) return 1'b0;
    case (m_mode[c])
      0:       return (m_nt[c] % 2) == 1;
      1:       return (m_nt[c] % 32) < m_duty[c];
      2:       return (m_lfsr[c] & 1) == 1;
      default: return m_nt[c] == 0;
    endcase
  endfunction

  function automatic logic [6:0] m_debug();
    logic [6:0] r;
    r = '0;
    r[6:4] = m_sel[2:0];
    for (int c = 0; c < NCH; c++) if (c < 4) r[c] = m_raw(c);
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_period[c] = 0; m_plo[c] = 0; m_pmid[c] = 0; m_duty[c] = 0;
      m_cnt[c] = 0; m_nt[c] = 0; m_mode[c] = 0; m_vol[c] = 0;
      m_en[c] = 1'b0; m_lfsr[c] = 1;
    end
    m_sel = 0; m_total = 0; m_sout = 1'b0; pend = 1'b0; pend_n = 0;
  endtask

  task automatic apply_write(int a, int d);
    int c, nm;
    c = m_sel;
    if (a == 7) m_sel = d & 7;
    else if (c < NCH) begin
      case (a)
        0: m_plo[c] = d;
        1: m_pmid[c] = d;
        2: m_period[c] = (d & 3) * 1024 + m_pmid[c] * 32 + m_plo[c];
        3: begin
          nm = (d >> 2) & 3;
          if (nm != m_mode[c]) begin m_cnt[c] = 0; m_nt[c] = 0; end
          m_en[c] = ((d >> 4) & 1) == 1;
          m_mode[c] = nm;
          m_vol[c] = d & 3;
          if (m_en[c] && nm == 3) begin m_cnt[c] = 0; m_nt[c] = 0; end
        end
        4: m_duty[c] = d;
        default: ;
      endcase
    end
  endtask

  task automatic model_update();
    int sum;
    longint prev;
    int unsigned fb;
    if (!ena) return;
    sum = 0;
    for (int c = 0; c < NCH; c++) if (m_raw(c)) sum += m_vol[c];
    prev = m_total;
    m_total = m_total + sum;
    m_sout = (m_total / FULL) != (prev / FULL);
    for (int c = 0; c < NCH; c++) begin
      if (!m_en[c]) begin
        m_cnt[c] = 0; m_nt[c] = 0;
      end else if (!(m_mode[c] == 3 && m_nt[c] >= 1)) begin
        if (m_cnt[c] >= m_period[c]) begin
          m_cnt[c] = 0;
          m_nt[c]++;
          if (m_mode[c] == 2) begin
            fb = ((m_lfsr[c] >> 14) ^ (m_lfsr[c] >> 13)) & 1;
            m_lfsr[c] = ((m_lfsr[c] << 1) | fb) & 32'h7fff;
          end
        end else m_cnt[c]++;
      end
    end
    if (pend) begin
      pend_n--;
      if (pend_n == 0) begin
        pend = 1'b0;
        apply_write(pend_a, pend_d);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_update();
    #1;
    cyc++;
    chk("cyc_debug", int'(debug), int'(m_debug()));
    chk("cyc_sout", int'(signal_out), int'(m_sout));
  endtask

  task automatic bus_write_start(int a, int d);
    address = 3'(a);
    data = 5'(d);
    write_strobe = 1'b1;
    pend = 1'b1; pend_n = 3; pend_a = a; pend_d = d;
  endtask

  // Returns right after the commit edge.
  task automatic bus_write_commit(int a, int d);
    bus_write_start(a, d);
    step(); step();
    write_strobe = 1'b0;
    step();
  endtask

  task automatic bus_write(int a, int d);
    bus_write_commit(a, d);
    step(); step();
  endtask

  task automatic wait_toggle(int idx, int maxn, output int n);
    logic p;
    p = debug[idx];
    n = 0;
    do begin
      step();
      n++;
    end while (debug[idx] == p && n < maxn);
  endtask

  typedef struct {
    int         a;
    int         d;
    logic [6:0] exp_dbg;
    bit         chk_so;
    bit         exp_so;
  } vec_t;

  vec_t vt[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, h, ones, a, d;
    logic [6:0] snap_dbg;
    logic snap_so, p;

    vt.push_back('{7, 0,  7'h00, 1, 0});
    vt.push_back('{0, 31, 7'h00, 1, 0});
    vt.push_back('{1, 31, 7'h00, 1, 0});
    vt.push_back('{2, 3,  7'h00, 1, 0});
    vt.push_back('{3, 31, 7'h01, 0, 0});
    vt.push_back('{7, 1,  7'h11, 0, 0});
    vt.push_back('{0, 31, 7'h11, 0, 0});
    vt.push_back('{1, 31, 7'h11, 0, 0});
    vt.push_back('{2, 3,  7'h11, 0, 0});
    vt.push_back('{3, 31, 7'h13, 0, 0});
    vt.push_back('{7, 2,  7'h23, 0, 0});
    vt.push_back('{0, 31, 7'h23, 0, 0});
    vt.push_back('{1, 31, 7'h23, 0, 0});
    vt.push_back('{2, 3,  7'h23, 0, 0});
    vt.push_back('{3, 31, 7'h27, 1, 1});
    vt.push_back('{7, 3,  7'h37, 1, 1});
    vt.push_back('{0, 5,  7'h37, 1, 1});
    vt.push_back('{7, 2,  7'h27, 1, 1});
    vt.push_back('{3, 23, 7'h23, 0, 0});
    vt.push_back('{7, 0,  7'h03, 0, 0});
    vt.push_back('{3, 0,  7'h02, 0, 0});
    vt.push_back('{7, 1,  7'h12, 0, 0});
    vt.push_back('{3, 0,  7'h10, 1, 0});

    rst_n = 1'b0; ena = 1'b1; write_strobe = 1'b0; address = '0; data = '0;
    model_reset();

    // Reset and idle
    step(); step();
    chk("rst_debug", int'(debug), 0);
    chk("rst_sout", int'(signal_out), 0);
    rst_n = 1'b1;
    repeat (1000) step();
    chk("idle_debug", int'(debug), 0);
    chk("idle_sout", int'(signal_out), 0);

    // Vector table
    foreach (vt[i]) begin
      bus_write(vt[i].a, vt[i].d);
      step(); step();
      chk($sformatf("vec%0d_debug", i), int'(debug), int'(vt[i].exp_dbg));
      if (vt[i].chk_so) chk($sformatf("vec%0d_sout", i), int'(signal_out), int'(vt[i].exp_so));
    end

    // Square on ch0, period 4
    bus_write(7, 0); bus_write(0, 4); bus_write(1, 0); bus_write(2, 0); bus_write(3, 19);
    wait_toggle(0, 20, n);
    for (int k = 0; k < 3; k++) begin
      wait_toggle(0, 20, n);
      chk("sq_interval", n, 5);
    end
    ones = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      ones += int'(signal_out);
    end
    checks++;
    if (ones < 49 || ones > 51) begin
      errors++;
      $display("FAIL sq_sout_density cyc=%0d got=%0d want=49..51", cyc, ones);
    end

    // PWM on ch1, period 0, duty 8 then 0
    bus_write(7, 1); bus_write(0, 0); bus_write(1, 0); bus_write(2, 0);
    bus_write(4, 8); bus_write(3, 23);
    for (int w = 0; w < 2; w++) begin
      h = 0;
      for (int k = 0; k < 32; k++) begin step(); h += int'(debug[1]); end
      chk("pwm_duty8", h, 8);
    end
    bus_write(4, 0);
    h = 0;
    for (int k = 0; k < 64; k++) begin step(); h += int'(debug[1]); end
    chk("pwm_duty0", h, 0);

    // Period staging on ch0
    bus_write(7, 0); bus_write(0, 8); bus_write(1, 31); bus_write(2, 0);
    wait_toggle(0, 1100, n);
    wait_toggle(0, 1100, n);
    chk("stage_p1000", n, 1001);
    bus_write(0, 3);
    wait_toggle(0, 1100, n);
    wait_toggle(0, 1100, n);
    chk("stage_plo_only", n, 1001);
    bus_write(1, 0);
    wait_toggle(0, 1100, n);
    repeat (10) step();
    bus_write_commit(2, 0);
    p = debug[0];
    step();
    chk("stage_tick_next", int'(debug[0]), int'(!p));
    wait_toggle(0, 20, n);
    chk("stage_p3_a", n, 4);
    wait_toggle(0, 20, n);
    chk("stage_p3_b", n, 4);
    bus_write(3, 0);

    // One-shot on ch2, period 9
    bus_write(7, 2); bus_write(0, 9); bus_write(1, 0); bus_write(2, 0);
    for (int r = 0; r < 2; r++) begin
      bus_write_commit(3, 31);
      h = int'(debug[2]);
      for (int k = 0; k < 40; k++) begin step(); h += int'(debug[2]); end
      chk("oneshot_len", h, 10);
      chk("oneshot_idle", int'(debug[2]), 0);
    end
    bus_write(7, 5); bus_write(0, 7);
    for (int k = 0; k < 20; k++) begin
      step();
      if (k % 5 == 0) chk("sel5_debug", int'(debug), 7'h50);
    end

    // ena low freezes everything
    bus_write(7, 0); bus_write(3, 19);
    repeat (20) step();
    ena = 1'b0;
    snap_dbg = debug; snap_so = signal_out;
    address = 3'd7; data = 5'd6;
    for (int k = 0; k < 50; k++) begin
      if (k == 10) write_strobe = 1'b1;
      if (k == 20) write_strobe = 1'b0;
      step();
      chk("ena_hold_debug", int'(debug), int'(snap_dbg));
      chk("ena_hold_sout", int'(signal_out), int'(snap_so));
    end
    ena = 1'b1;
    repeat (10) step();
    chk("ena_strobe_ignored", int'(debug[6:4]), 0);

    // Reset during a staged period write
    bus_write(0, 7);
    bus_write_start(2, 1);
    step(); step();
    rst_n = 1'b0; write_strobe = 1'b0;
    model_reset();
    #1;
    chk("midrst_debug", int'(debug), 0);
    step(); step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("midrst_debug_after", int'(debug), 0);
    chk("midrst_sout_after", int'(signal_out), 0);
    bus_write(3, 19);
    wait_toggle(0, 10, n);
    chk("midrst_period0_a", n, 1);
    wait_toggle(0, 10, n);
    chk("midrst_period0_b", n, 1);

    // Random bus traffic against the model
    for (int it = 0; it < 120; it++) begin
      a = $urandom_range(0, 7);
      d = $urandom_range(0, 31);
      if (a == 1 && $urandom_range(0, 3) != 0) d = 0;
      if (a == 2 && $urandom_range(0, 3) != 0) d = d & 28;
      if (a == 7) d = $urandom_range(0, 3);
      bus_write(a, d);
      repeat ($urandom_range(0, 30)) step();
      if ($urandom_range(0, 9) == 0) begin
        ena = 1'b0;
        repeat ($urandom_range(1, 8)) step();
        ena = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
